// File: rtl/bus_pkg.sv
// Shared constants and helpers for the datapath bus receive logic.
package bus_pkg;
    localparam int BUS_WIDTH   = 16;
    localparam int BUS_DRIVERS = 4;

    localparam int DRV_ALU = 0;
    localparam int DRV_MEM = 1;
    localparam int DRV_REG = 2;
    localparam int DRV_IMM = 3;

    // Operates on a zero-extended copy so any driver count up to 32 works.
    function automatic logic onehot_check(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction
endpackage

// File: rtl/bus_rx_fifo.sv
// Circular word store with read/write pointers and an occupancy count.
module bus_rx_fifo
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [AW-1:0]                    r_wr_ptr;
    logic [AW-1:0]                    r_rd_ptr;
    logic [CW-1:0]                    r_count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/bus_capture_fifo.sv
// Bus receive end: validates driver enables on load, queues the word, flags errors.
module bus_capture_fifo
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH  = BUS_WIDTH,
    parameter int DEPTH       = 4,
    parameter int NUM_DRIVERS = BUS_DRIVERS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    bus_data,
    input  logic [NUM_DRIVERS-1:0]   drv_enable,
    input  logic                     load,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     bus_err,
    output logic                     overflow,
    input  logic                     err_clear
);
    logic w_onehot;
    logic w_pop;
    logic w_push_ok;
    logic w_bad_bus;
    logic w_drop;
    logic r_bus_err;
    logic r_overflow;

    assign w_onehot  = onehot_check(32'(drv_enable));
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = load & w_onehot & (~full | w_pop);
    assign w_bad_bus = load & ~w_onehot;
    assign w_drop    = load & w_onehot & full & ~w_pop;

    bus_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_data  (bus_data),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_full  (full),
        .o_count (count)
    );

    // A fresh error outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bus_err  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_bad_bus) begin
                r_bus_err <= 1'b1;
            end else if (err_clear) begin
                r_bus_err <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus_err  = r_bus_err;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed and randomized checks of bus_capture_fifo against a queue model.
module tb_bus_capture_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int ND    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] bus_data = '0;
    logic [ND-1:0] drv_enable = '0;
    logic          load = 1'b0;
    logic          out_ready = 1'b0;
    logic          err_clear = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          full;
    logic [2:0]    count;
    logic          bus_err;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    logic [DW-1:0] mq[$];
    bit m_err = 1'b0;
    bit m_ovf = 1'b0;

    bus_capture_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_DRIVERS(ND)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_data   (bus_data),
        .drv_enable (drv_enable),
        .load       (load),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .count      (count),
        .bus_err    (bus_err),
        .overflow   (overflow),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of stored words plus two sticky bits.
    always @(posedge clk) begin
        bit pop, one, ok;
        if (!reset_n) begin
            mq.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
        end else begin
            pop = (mq.size() != 0) && out_ready;
            one = ($countones(drv_enable) == 1);
            ok  = load && one && ((mq.size() < DEPTH) || pop);
            if (load && !one) m_err = 1'b1;
            else if (err_clear) m_err = 1'b0;
            if (load && one && !ok) m_ovf = 1'b1;
            else if (err_clear) m_ovf = 1'b0;
            if (pop) void'(mq.pop_front());
            if (ok) mq.push_back(bus_data);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("bus_err", 32'(bus_err), 32'(m_err));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [ND-1:0] drv);
        load = 1'b1; bus_data = d; drv_enable = drv;
        tick();
        load = 1'b0; drv_enable = '0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        tick(); tick();
        armed = 1'b1;
        reset_n = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_flags", 32'({bus_err, overflow}), 0);

        push(16'hA5A5, 4'b0001);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 32'h0000A5A5);
        chk("t1_count", 32'(count), 1);
        pop1();
        chk("t1_pop_valid", 32'(out_valid), 0);
        chk("t1_pop_count", 32'(count), 0);

        for (int i = 1; i <= 4; i++) push(16'(i), 4'(1 << (i % 4)));
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 4);
        push(16'h0005, 4'b0001);
        chk("t2_overflow", 32'(overflow), 1);
        chk("t2_count_ovf", 32'(count), 4);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", 32'(out_data), 32'(i));
            pop1();
        end
        chk("t2_empty", 32'(out_valid), 0);
        clear_errs();
        chk("t2_ovf_clr", 32'(overflow), 0);

        for (int i = 1; i <= 4; i++) push(16'(i), 4'b0010);
        load = 1'b1; bus_data = 16'h0BEE; drv_enable = 4'b1000; out_ready = 1'b1;
        tick();
        load = 1'b0; drv_enable = '0; out_ready = 1'b0;
        chk("t3_count", 32'(count), 4);
        chk("t3_overflow", 32'(overflow), 0);
        for (int i = 2; i <= 4; i++) begin
            chk("t3_order", 32'(out_data), 32'(i));
            pop1();
        end
        chk("t3_last", 32'(out_data), 32'h00000BEE);
        pop1();
        chk("t3_empty", 32'(count), 0);

        push(16'h1111, 4'b0000);
        push(16'h2222, 4'b0110);
        chk("t4_bus_err", 32'(bus_err), 1);
        chk("t4_count", 32'(count), 0);
        clear_errs();
        chk("t4_clr", 32'(bus_err), 0);
        err_clear = 1'b1;
        push(16'h3333, 4'b1111);
        err_clear = 1'b0;
        chk("t4_set_wins", 32'(bus_err), 1);
        clear_errs();

        for (int i = 0; i < 3; i++) push(16'h7000 + 16'(i), 4'b0100);
        push(16'h4444, 4'b0000);
        chk("t5_pre_count", 32'(count), 3);
        chk("t5_pre_err", 32'(bus_err), 1);
        reset_n = 1'b0; load = 1'b1; drv_enable = 4'b0001; bus_data = 16'h1234;
        tick();
        reset_n = 1'b1; load = 1'b0; drv_enable = '0;
        chk("t5_count", 32'(count), 0);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_flags", 32'({bus_err, overflow}), 0);
        chk("t5_data", 32'(out_data), 0);

        for (int i = 0; i < 10; i++) begin
            push(16'hC000 + 16'(i), 4'(1 << (i % 4)));
            chk("t6_wrap", 32'(out_data), 32'hC000 + 32'(i));
            pop1();
        end
        chk("t6_empty", 32'(count), 0);

        for (int n = 0; n < 800; n++) begin
            load       = 1'($urandom_range(0, 1));
            bus_data   = 16'($urandom);
            drv_enable = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3))
                                                     : 4'($urandom);
            out_ready  = ($urandom_range(0, 9) < 4);
            err_clear  = ($urandom_range(0, 9) == 0);
            reset_n    = ($urandom_range(0, 49) != 0);
            tick();
        end
        load = 1'b0; out_ready = 1'b0; err_clear = 1'b0; reset_n = 1'b1; drv_enable = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
